// File: rtl/helix_pkg.sv
// Shared Helix4 die types and constants used by the actuator bridge.
// Action width is fixed here so the die and its downstream stages agree on it.
package helix_pkg;

    localparam int HELIX_ACTION_W = 16;

    // World-port code returned when the actuator never acknowledges.
    localparam logic [HELIX_ACTION_W-1:0] HELIX_ACT_TIMEOUT_CODE = '1;

    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_ISSUE,
        ACT_REPORT
    } helix_act_state_e;

endpackage

// File: rtl/helix_sync_fifo.sv
// Single-clock FIFO with a fall-through head (dout is valid whenever !empty).
// Pointers carry one extra wrap bit so full and empty can be told apart.
module helix_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    assign dout  = mem_q[rd_q[AW-1:0]];
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count = wr_q - rd_q;

endmodule

// File: rtl/helix_actuator_bridge.sv
// Buffers die actions, issues each to the actuator over req/ack with a timeout,
// and returns the actuator result (or the timeout code) to the die world port.
module helix_actuator_bridge
    import helix_pkg::*;
#(
    parameter int ACTION_W    = HELIX_ACTION_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int ERR_W       = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            action_valid,
    output logic                            action_ready,
    input  logic [ACTION_W-1:0]             action_data,
    output logic                            act_req,
    output logic [ACTION_W-1:0]             act_cmd,
    input  logic                            act_ack,
    input  logic [ACTION_W-1:0]             act_resp,
    output logic                            world_valid,
    input  logic                            world_ready,
    output logic [ACTION_W-1:0]             world_data,
    output logic                            timeout_pulse,
    output logic [ERR_W-1:0]                err_count,
    output logic [$clog2(FIFO_DEPTH)+1:0]   in_flight
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]       CNT_LAST     = CW'(TIMEOUT_CYC - 1);
    localparam logic [ACTION_W-1:0] TIMEOUT_CODE = '1;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ACTION_W-1:0] fifo_dout;
    logic [AW:0]         fifo_count;

    helix_act_state_e    state_q, state_d;
    logic [ACTION_W-1:0] cmd_q, cmd_d;
    logic [ACTION_W-1:0] world_data_q, world_data_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                req_q, req_d;
    logic                wvalid_q, wvalid_d;
    logic                tpulse_q, tpulse_d;

    // Ready deliberately ignores same-cycle pops so it is a pure register decode.
    assign action_ready = !fifo_full && !rst;
    assign fifo_push    = action_valid && action_ready;

    helix_sync_fifo #(
        .W     (ACTION_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (action_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACT_IDLE;
            cmd_q        <= '0;
            world_data_q <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            req_q        <= 1'b0;
            wvalid_q     <= 1'b0;
            tpulse_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            world_data_q <= world_data_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            req_q        <= req_d;
            wvalid_q     <= wvalid_d;
            tpulse_q     <= tpulse_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        world_data_d = world_data_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        req_d        = req_q;
        wvalid_d     = wvalid_q;
        tpulse_d     = 1'b0;
        fifo_pop     = 1'b0;

        case (state_q)
            ACT_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_dout;
                    cnt_d    = '0;
                    req_d    = 1'b1;
                    state_d  = ACT_ISSUE;
                end
            end
            ACT_ISSUE: begin
                // An ack on the expiry edge takes priority over the timeout.
                if (act_ack) begin
                    world_data_d = act_resp;
                    req_d        = 1'b0;
                    wvalid_d     = 1'b1;
                    state_d      = ACT_REPORT;
                end else if (cnt_q == CNT_LAST) begin
                    world_data_d = TIMEOUT_CODE;
                    tpulse_d     = 1'b1;
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    req_d    = 1'b0;
                    wvalid_d = 1'b1;
                    state_d  = ACT_REPORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACT_REPORT: begin
                if (world_ready) begin
                    wvalid_d = 1'b0;
                    state_d  = ACT_IDLE;
                end
            end
            default: begin
                state_d = ACT_IDLE;
            end
        endcase
    end

    assign act_req       = req_q;
    assign act_cmd       = cmd_q;
    assign world_valid   = wvalid_q;
    assign world_data    = world_data_q;
    assign timeout_pulse = tpulse_q;
    assign err_count     = err_q;
    // The action held by the FSM (ISSUE or REPORT) counts as in flight.
    assign in_flight     = {1'b0, fifo_count} + (AW + 2)'(state_q != ACT_IDLE);

endmodule
